hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Parametrised hazard and stall controller for the 5-stage pipeline.
- Sequences multi-register memory ops (LM/SM/LA/SA) in MEM: an internal transfer index, with a front-end freeze for the op's duration.
- Detects load-use hazards between DEC and EX and holds DEC for a configurable number of cycles, injecting bubbles into EX.
- Sits beside the pipeline registers and drives their hold/bubble enables.

Parameters:
- REG_ADDR_W, 3, register address width
- OPCODE_W, 4, opcode width
- NUM_XFER, 8, registers moved per multi-register op (2..2**REG_ADDR_W)
- LOAD_STALL_CYCLES, 1, DEC stall cycles per load-use hazard (1..3)
- OP_LW, 4'b0100, single load opcode
- OP_LM / OP_SM / OP_LA / OP_SA, 4'b1100 / 4'b1101 / 4'b1110 / 4'b1111, multi-register opcodes

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- dec_src1, dec_src2  in  REG_ADDR_W  DEC source addresses
- dec_src1_used, dec_src2_used  in  1  source actually read
- exe_valid  in  1  EX holds a valid instruction
- exe_opcode  in  OPCODE_W  EX opcode
- exe_dest  in  REG_ADDR_W  EX destination
- mem_valid  in  1  MEM holds a valid instruction
- mem_opcode  in  OPCODE_W  MEM opcode
- flush  in  1  branch flush of IF/DEC
- freeze_front  out  1  hold PC, IF/DEC, DEC/EX, EX/MEM
- stall_dec  out  1  hold PC and IF/DEC
- bubble_exe  out  1  load NOP into DEC/EX
- xfer_idx  out  REG_ADDR_W  current transfer register index
- xfer_last  out  1  final transfer cycle
- busy  out  1  FSM not IDLE

Behaviour:
- Reset (async) puts the FSM in IDLE and clears the xfer counter and stall counter. All outputs are 0 while reset is high.
- multi_hit = mem_valid and mem_opcode in {LM,SM,LA,SA}.
- FSM states: IDLE, MULTI.
- IDLE with multi_hit: xfer_idx=0 and freeze_front=1 combinationally in the same cycle. Next state MULTI, counter=1.
- MULTI: xfer_idx=counter, and the counter increments every cycle. mem_valid/opcode are ignored (no re-trigger).
- freeze_front=1 while xfer_idx <= NUM_XFER-2.
- xfer_idx==NUM_XFER-1: xfer_last=1, freeze_front=0, next state IDLE.
- A multi op therefore occupies MEM for exactly NUM_XFER cycles, with freeze_front high for NUM_XFER-1 of them.
- If NUM_XFER-1 is reached from IDLE (NUM_XFER=2 degenerate case), the same rule applies.
- busy=1 in MULTI.
- load_use = exe_valid and one of:
  - exe_opcode==OP_LW and ((dec_src1_used and dec_src1==exe_dest) or (dec_src2_used and dec_src2==exe_dest));
  - exe_opcode in {OP_LM, OP_LA}, unconditionally (destinations unknown at DEC).
- Stall counter scnt, width 2:
  - stall_dec = (load_use or scnt!=0) and not freeze_front.
  - bubble_exe = stall_dec.
  - When load_use and scnt==0 and not freeze_front, scnt loads LOAD_STALL_CYCLES-1.
  - Otherwise a nonzero scnt decrements each cycle that freeze_front=0.
- Priority: freeze_front dominates. While freeze_front=1, load_use is not evaluated and scnt holds. The hazard re-evaluates in the first unfrozen cycle because EX is held.
- flush=1 clears scnt to 0 and forces stall_dec/bubble_exe to 0 that cycle. flush does not affect the MULTI sequence, since the MEM op is older than the branch.
- load_use and scnt!=0 in the same cycle: scnt keeps decrementing with no reload; a new hazard is detected after scnt reaches 0.
- Reset mid-MULTI returns to IDLE immediately and the transfer is abandoned. The MEM stage is also reset.
- Address compares are full-width equality. There is no register-0 exemption.

Test Plan:
- Reset: hold reset 3 cycles with mem_opcode=1100, mem_valid=1 -> all outputs 0. Release -> xfer_idx=0 and freeze_front=1 in the release cycle.
- LM, NUM_XFER=8: mem_valid=1, opcode 1100 -> xfer_idx 0..7 over 8 cycles, freeze_front=1 for idx 0..6, xfer_last=1 only at idx 7, busy drops the cycle after.
- LW hazard, LOAD_STALL_CYCLES=2: exe_opcode=0100, exe_dest=3, dec_src2=3 used -> stall_dec=bubble_exe=1 for 2 cycles, then 0. With dec_src2_used=0 -> no stall.
- EX LA: exe_opcode=1110, no address match -> 1-cycle stall_dec (LOAD_STALL_CYCLES=1).
- Simultaneous: multi op in MEM plus LW hazard in EX -> stall_dec=0 during freeze. Stall asserts in the first cycle freeze_front=0 (xfer_idx=7).
- Flush during a 3-cycle load stall, at its 2nd cycle -> stall_dec=0 immediately, scnt=0. An in-flight MULTI sequence continues unaffected.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: sequences multi-register MEM ops with a front-end
// freeze, and holds DEC with EX bubbles on load-use hazards.
module hazard_stall_ctrl #(
    parameter int                    REG_ADDR_W        = 3,
    parameter int                    OPCODE_W          = 4,
    parameter int                    NUM_XFER          = 8,
    parameter int                    LOAD_STALL_CYCLES = 1,
    parameter logic [OPCODE_W-1:0]   OP_LW             = 4'b0100,
    parameter logic [OPCODE_W-1:0]   OP_LM             = 4'b1100,
    parameter logic [OPCODE_W-1:0]   OP_SM             = 4'b1101,
    parameter logic [OPCODE_W-1:0]   OP_LA             = 4'b1110,
    parameter logic [OPCODE_W-1:0]   OP_SA             = 4'b1111
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] dec_src1,
    input  logic [REG_ADDR_W-1:0] dec_src2,
    input  logic                  dec_src1_used,
    input  logic                  dec_src2_used,
    input  logic                  exe_valid,
    input  logic [OPCODE_W-1:0]   exe_opcode,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  mem_valid,
    input  logic [OPCODE_W-1:0]   mem_opcode,
    input  logic                  flush,
    output logic                  freeze_front,
    output logic                  stall_dec,
    output logic                  bubble_exe,
    output logic [REG_ADDR_W-1:0] xfer_idx,
    output logic                  xfer_last,
    output logic                  busy
);

    typedef enum logic [0:0] {IDLE = 1'b0, MULTI = 1'b1} state_t;

    localparam logic [REG_ADDR_W-1:0] LAST_IDX   = REG_ADDR_W'(NUM_XFER - 1);
    localparam logic [1:0]            STALL_LOAD = 2'(LOAD_STALL_CYCLES - 1);

    state_t                state_q, state_d;
    logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
    logic [1:0]            scnt_q, scnt_d;

    logic                  multi_hit;
    logic                  active;
    logic [REG_ADDR_W-1:0] idx;
    logic                  last;
    logic                  freeze;
    logic                  load_use;
    logic                  stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
        end
    end

    assign multi_hit = mem_valid &&
                       (mem_opcode == OP_LM || mem_opcode == OP_SM ||
                        mem_opcode == OP_LA || mem_opcode == OP_SA);

    // Transfer sequencer; the first transfer happens in the IDLE cycle itself.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        active  = 1'b0;
        idx     = '0;
        case (state_q)
            IDLE: begin
                if (multi_hit) begin
                    active = 1'b1;
                    idx    = '0;
                end
            end
            MULTI: begin
                active = 1'b1;
                idx    = cnt_q;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        last   = active && (idx == LAST_IDX);
        freeze = active && !last;
        if (active) begin
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = MULTI;
                cnt_d   = idx + 1'b1;
            end
        end
    end

    // LM/LA destinations are not known at DEC, so they always stall.
    assign load_use = exe_valid &&
                      (((exe_opcode == OP_LW) &&
                        ((dec_src1_used && dec_src1 == exe_dest) ||
                         (dec_src2_used && dec_src2 == exe_dest))) ||
                       exe_opcode == OP_LM || exe_opcode == OP_LA);

    always_comb begin
        scnt_d = scnt_q;
        stall  = 1'b0;
        if (!freeze) begin
            stall = (load_use || scnt_q != 2'd0) && !flush;
            if (scnt_q != 2'd0)
                scnt_d = scnt_q - 2'd1;
            else if (load_use)
                scnt_d = STALL_LOAD;
        end
        if (flush)
            scnt_d = 2'd0;
    end

    assign freeze_front = freeze && !reset;
    assign stall_dec    = stall && !reset;
    assign bubble_exe   = stall && !reset;
    assign xfer_idx     = reset ? '0 : idx;
    assign xfer_last    = last && !reset;
    assign busy         = (state_q == MULTI) && !reset;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: three instances differing only in load stall length,
// driven with shared stimulus and checked every cycle at the falling edge.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dec_src1, dec_src2, exe_dest;
    logic       dec_src1_used, dec_src2_used;
    logic       exe_valid, mem_valid, flush;
    logic [3:0] exe_opcode, mem_opcode;

    logic       ff [3], sd [3], bx [3], xl [3], bz [3];
    logic [2:0] xi [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            hazard_stall_ctrl #(
                .NUM_XFER(8),
                .LOAD_STALL_CYCLES(gi + 1)
            ) u_dut (
                .clk(clk), .reset(reset),
                .dec_src1(dec_src1), .dec_src2(dec_src2),
                .dec_src1_used(dec_src1_used), .dec_src2_used(dec_src2_used),
                .exe_valid(exe_valid), .exe_opcode(exe_opcode), .exe_dest(exe_dest),
                .mem_valid(mem_valid), .mem_opcode(mem_opcode), .flush(flush),
                .freeze_front(ff[gi]), .stall_dec(sd[gi]), .bubble_exe(bx[gi]),
                .xfer_idx(xi[gi]), .xfer_last(xl[gi]), .busy(bz[gi])
            );
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Checks the current cycle at negedge, then advances to just after posedge.
    task automatic cyc(input string tag, input logic f, input logic [2:0] idx,
                       input logic l, input logic b, input logic s1,
                       input logic s2, input logic s3);
        logic [2:0] st;
        st = {s3, s2, s1};
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check_eq($sformatf("%s_s%0d", tag, k + 1),
                     {24'd0, ff[k], sd[k], bx[k], xi[k], xl[k], bz[k]},
                     {24'd0, f, st[k], st[k], idx, l, b});
        $display("cyc %-12s ff=%b idx=%0d last=%b busy=%b stall=%b%b%b",
                 tag, ff[0], xi[0], xl[0], bz[0], sd[0], sd[1], sd[2]);
        @(posedge clk);
        #1;
    endtask

    task automatic lw_hazard();
        exe_valid = 1'b1; exe_opcode = 4'b0100; exe_dest = 3'd3;
        dec_src1 = 3'd5; dec_src1_used = 1'b0;
        dec_src2 = 3'd3; dec_src2_used = 1'b1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        mem_valid = 1'b1; mem_opcode = 4'b1100;
        exe_valid = 1'b0; exe_opcode = 4'b0000; exe_dest = 3'd0;
        dec_src1 = 3'd0; dec_src2 = 3'd0; dec_src1_used = 1'b0; dec_src2_used = 1'b0;
        #1;

        // Reset held 3 cycles with a multi op pending in MEM
        for (int i = 0; i < 3; i++) cyc($sformatf("rst%0d", i), 0, 0, 0, 0, 0, 0, 0);

        // Release: LM begins in the release cycle and runs 8 transfers
        reset = 1'b0;
        cyc("lm0", 1, 0, 0, 0, 0, 0, 0);
        mem_valid = 1'b0;
        for (int i = 1; i < 7; i++) cyc($sformatf("lm%0d", i), 1, 3'(i), 0, 1, 0, 0, 0);
        cyc("lm7", 0, 7, 1, 1, 0, 0, 0);
        cyc("lm_done", 0, 0, 0, 0, 0, 0, 0);

        // Non-multi in MEM and a multi opcode without valid never freeze
        mem_valid = 1'b1; mem_opcode = 4'b0100;
        cyc("mem_lw", 0, 0, 0, 0, 0, 0, 0);
        mem_valid = 1'b0; mem_opcode = 4'b1101;
        cyc("mem_inv", 0, 0, 0, 0, 0, 0, 0);

        // LW hazard on src2; EX takes a bubble after the first cycle
        lw_hazard();
        cyc("lw_c0", 0, 0, 0, 0, 1, 1, 1);
        exe_valid = 1'b0;
        cyc("lw_c1", 0, 0, 0, 0, 0, 1, 1);
        cyc("lw_c2", 0, 0, 0, 0, 0, 0, 1);
        cyc("lw_c3", 0, 0, 0, 0, 0, 0, 0);

        // Matching address but source not used
        lw_hazard(); dec_src2_used = 1'b0; dec_src1_used = 1'b1;
        cyc("lw_unused", 0, 0, 0, 0, 0, 0, 0);
        exe_valid = 1'b0;

        // LA in EX stalls unconditionally
        exe_valid = 1'b1; exe_opcode = 4'b1110; exe_dest = 3'd6;
        dec_src1 = 3'd1; dec_src2 = 3'd2; dec_src1_used = 1'b1; dec_src2_used = 1'b1;
        cyc("la_c0", 0, 0, 0, 0, 1, 1, 1);
        exe_valid = 1'b0;
        cyc("la_c1", 0, 0, 0, 0, 0, 1, 1);
        cyc("la_c2", 0, 0, 0, 0, 0, 0, 1);
        cyc("la_c3", 0, 0, 0, 0, 0, 0, 0);

        // SM in MEM with LW hazard held in EX: stall only once unfrozen
        mem_valid = 1'b1; mem_opcode = 4'b1101; lw_hazard();
        cyc("sim0", 1, 0, 0, 0, 0, 0, 0);
        mem_valid = 1'b0;
        for (int i = 1; i < 7; i++) cyc($sformatf("sim%0d", i), 1, 3'(i), 0, 1, 0, 0, 0);
        cyc("sim7", 0, 7, 1, 1, 1, 1, 1);
        exe_valid = 1'b0;
        cyc("sim_a", 0, 0, 0, 0, 0, 1, 1);
        cyc("sim_b", 0, 0, 0, 0, 0, 0, 1);
        cyc("sim_c", 0, 0, 0, 0, 0, 0, 0);

        // Flush on 2nd cycle of a load stall kills it and clears the counter
        lw_hazard();
        cyc("fl_c0", 0, 0, 0, 0, 1, 1, 1);
        exe_valid = 1'b0; flush = 1'b1;
        cyc("fl_c1", 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b0;
        cyc("fl_c2", 0, 0, 0, 0, 0, 0, 0);

        // Flush throughout an SA sequence does not disturb it
        mem_valid = 1'b1; mem_opcode = 4'b1111; flush = 1'b1;
        cyc("fsa0", 1, 0, 0, 0, 0, 0, 0);
        mem_valid = 1'b0;
        for (int i = 1; i < 7; i++) cyc($sformatf("fsa%0d", i), 1, 3'(i), 0, 1, 0, 0, 0);
        cyc("fsa7", 0, 7, 1, 1, 0, 0, 0);
        flush = 1'b0;
        cyc("fsa_done", 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-LM abandons the transfer
        mem_valid = 1'b1; mem_opcode = 4'b1100;
        cyc("rm0", 1, 0, 0, 0, 0, 0, 0);
        mem_valid = 1'b0;
        cyc("rm1", 1, 1, 0, 1, 0, 0, 0);
        cyc("rm2", 1, 2, 0, 1, 0, 0, 0);
        reset = 1'b1;
        cyc("rm_rst", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc("rm_after", 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
